// File: rtl/operand_fetch.sv
// Register file and operand stage feeding the 16-bit ALU.
// Reads a = R[rd] and b = R[rs] or imm, with write-back bypass.
// A per-register pending scoreboard stalls read-after-write hazards.
module operand_fetch #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs,
  input  logic          in_use_imm,
  input  logic [DW-1:0] in_imm,
  input  logic [2:0]    in_com,
  input  logic          in_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_com,
  output logic [AW-1:0] out_rd,
  output logic          out_we,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          flush
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic            wb_hit_rd;
  logic            wb_hit_rs;
  logic            hazard;
  logic            accept;
  logic [DW-1:0]   rd_val;
  logic [DW-1:0]   rs_val;

  // Bypassed reads, hazard detection and the stage handshake
  always_comb begin
    wb_hit_rd = wb_en && (wb_addr == in_rd);
    wb_hit_rs = wb_en && (wb_addr == in_rs);
    rd_val    = wb_hit_rd ? wb_data : regs[in_rd];
    rs_val    = wb_hit_rs ? wb_data : regs[in_rs];
    hazard    = (pend[in_rd] && !wb_hit_rd) ||
                (!in_use_imm && pend[in_rs] && !wb_hit_rs);
    in_ready  = (!out_valid || out_ready) && !hazard && !flush;
    accept    = in_valid && in_ready;
  end

  // Scoreboard update: clears applied first so a same-cycle set wins
  always_comb begin
    pend_nxt = pend;
    if (wb_en)
      pend_nxt[wb_addr] = 1'b0;
    if (flush && out_valid && out_we)
      pend_nxt[out_rd] = 1'b0;
    if (accept && in_we)
      pend_nxt[in_rd] = 1'b1;
  end

  // Register file write port; writes land regardless of stall or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Pending-write scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend <= '0;
    else
      pend <= pend_nxt;
  end

  // Output operation register: flush beats accept, drain keeps data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_com   <= 3'b000;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_a     <= rd_val;
      alu_b     <= in_use_imm ? in_imm : rs_val;
      alu_com   <= in_com;
      out_rd    <= in_rd;
      out_we    <= in_we;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic [2:0]  in_com;
  logic        in_we;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_com;
  logic [2:0]  out_rd;
  logic        out_we;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flush;

  int checks = 0;
  int errors = 0;

  operand_fetch #(.DW(16), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs(in_rs), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_com(in_com), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_com(alu_com),
    .out_rd(out_rd), .out_we(out_we),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [15:0] mreg [8];
  bit          mpend [8];
  bit          mov;
  logic [15:0] ma, mb;
  logic [2:0]  mcom, mrd;
  bit          mwe;

  function automatic logic [15:0] mread(input logic [2:0] r);
    if (wb_en && wb_addr == r) return wb_data;
    return mreg[r];
  endfunction

  function automatic bit mwaiting(input logic [2:0] r);
    return mpend[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic bit m_ready();
    bit stall;
    stall = mwaiting(in_rd) || (!in_use_imm && mwaiting(in_rs));
    return (!mov || out_ready) && !stall && !flush;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mreg[i]  = 16'h0;
        mpend[i] = 1'b0;
      end
      mov = 0; ma = 0; mb = 0; mcom = 0; mrd = 0; mwe = 0;
    end else begin
      bit acc;
      logic [15:0] na, nb;
      acc = in_valid && m_ready();
      na  = mread(in_rd);
      nb  = in_use_imm ? in_imm : mread(in_rs);
      if (wb_en) begin
        mreg[wb_addr]  = wb_data;
        mpend[wb_addr] = 1'b0;
      end
      if (flush && mov && mwe) mpend[mrd] = 1'b0;
      if (acc && in_we) mpend[in_rd] = 1'b1;
      if (flush) mov = 0;
      else if (acc) begin
        mov = 1; ma = na; mb = nb; mcom = in_com; mrd = in_rd; mwe = in_we;
      end else if (out_ready) mov = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", 32'(in_ready), 32'(m_ready()));
      chk("m_out_valid", 32'(out_valid), 32'(mov));
      chk("m_alu_a", 32'(alu_a), 32'(ma));
      chk("m_alu_b", 32'(alu_b), 32'(mb));
      chk("m_alu_com", 32'(alu_com), 32'(mcom));
      chk("m_out_rd", 32'(out_rd), 32'(mrd));
      chk("m_out_we", 32'(out_we), 32'(mwe));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rd = 0; in_rs = 0; in_use_imm = 0; in_imm = 0;
    in_com = 0; in_we = 0; out_ready = 1; wb_en = 0; wb_addr = 0;
    wb_data = 0; flush = 0;
  endtask

  task automatic issue(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] com,
                       input logic we, input logic ui, input logic [15:0] imm);
    in_valid = 1; in_rd = rd; in_rs = rs; in_com = com; in_we = we;
    in_use_imm = ui; in_imm = imm;
  endtask

  task automatic wb(input logic [2:0] a, input logic [15:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    idle();
    rst_n = 0;
    // reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_alu_com", 32'(alu_com), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_out_we", 32'(out_we), 0);
    cyc();
    rst_n = 1;

    // 1: write-back r3 then read it as operand a
    wb(3, 16'h1234); cyc();
    idle(); issue(3, 0, 3'b110, 0, 0, 0);
    @(negedge clk); chk("t1_ready", 32'(in_ready), 1);
    cyc(); idle();
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_a", 32'(alu_a), 32'h1234);
    chk("t1_b", 32'(alu_b), 0);
    chk("t1_com", 32'(alu_com), 32'b110);
    cyc();

    // 2: same-cycle write-back bypass
    wb(2, 16'hBEEF); issue(1, 2, 3'b101, 0, 0, 0); cyc(); idle();
    @(negedge clk);
    chk("t2_b_bypass", 32'(alu_b), 32'hBEEF);
    chk("t2_a", 32'(alu_a), 0);
    cyc();
    issue(2, 2, 3'b000, 0, 0, 0); cyc(); idle();
    @(negedge clk); chk("t2_r2_after", 32'(alu_a), 32'hBEEF);
    cyc();

    // 3: immediate replaces rs
    wb(5, 16'hAAAA); cyc(); idle();
    issue(3, 5, 3'b100, 0, 1, 16'h00FF); cyc(); idle();
    @(negedge clk);
    chk("t3_b_imm", 32'(alu_b), 32'h00FF);
    chk("t3_a", 32'(alu_a), 32'h1234);
    cyc();

    // 4: hold under back-pressure, then accept on release
    out_ready = 0; issue(2, 3, 3'b001, 0, 0, 0); cyc();
    issue(3, 5, 3'b010, 0, 0, 0); out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_ready", 32'(in_ready), 0);
      chk("t4_hold_a", 32'(alu_a), 32'hBEEF);
      chk("t4_hold_com", 32'(alu_com), 32'b001);
      chk("t4_hold_valid", 32'(out_valid), 1);
      cyc();
    end
    out_ready = 1;
    @(negedge clk); chk("t4_release_ready", 32'(in_ready), 1);
    cyc(); idle();
    @(negedge clk);
    chk("t4_new_a", 32'(alu_a), 32'h1234);
    chk("t4_new_b", 32'(alu_b), 32'hAAAA);
    chk("t4_new_com", 32'(alu_com), 32'b010);
    cyc();

    // 5: RAW stall until write-back of r4, accepted the same cycle
    issue(4, 0, 3'b110, 1, 0, 0); cyc(); idle();
    issue(4, 0, 3'b111, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("t5_stall", 32'(in_ready), 0);
      cyc();
    end
    wb(4, 16'h0005);
    @(negedge clk); chk("t5_wb_ready", 32'(in_ready), 1);
    cyc(); idle();
    @(negedge clk);
    chk("t5_a", 32'(alu_a), 32'h0005);
    chk("t5_com", 32'(alu_com), 32'b111);
    cyc();

    // 6: flush of a held writing op clears its pending bit
    out_ready = 0; issue(5, 0, 3'b011, 1, 0, 0); cyc();
    out_ready = 0; flush = 1; issue(1, 2, 3'b100, 0, 0, 0);
    @(negedge clk); chk("t6_flush_ready", 32'(in_ready), 0);
    cyc(); idle();
    issue(5, 5, 3'b010, 0, 0, 0);
    @(negedge clk);
    chk("t6_valid_off", 32'(out_valid), 0);
    chk("t6_no_stall", 32'(in_ready), 1);
    cyc(); idle();
    @(negedge clk);
    chk("t6_a", 32'(alu_a), 32'hAAAA);
    chk("t6_com", 32'(alu_com), 32'b010);
    cyc();

    // 7: asynchronous reset mid-operation
    issue(6, 0, 3'b101, 1, 0, 0); cyc(); idle(); out_ready = 0;
    rst_n = 0; #1;
    chk("t7_valid", 32'(out_valid), 0);
    chk("t7_com", 32'(alu_com), 0);
    chk("t7_we", 32'(out_we), 0);
    @(posedge clk); #1; rst_n = 1; out_ready = 1;
    issue(6, 3, 3'b001, 0, 0, 0);
    @(negedge clk); chk("t7_pend_clear", 32'(in_ready), 1);
    cyc(); idle();
    @(negedge clk); chk("t7_r3_cleared", 32'(alu_b), 0);
    cyc();

    // Mixed traffic, checked by the model each cycle
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rd      = 3'($urandom_range(0, 7));
      in_rs      = 3'($urandom_range(0, 7));
      in_use_imm = ($urandom_range(0, 3) == 0);
      in_imm     = 16'($urandom);
      in_com     = 3'($urandom_range(0, 7));
      in_we      = ($urandom_range(0, 1) == 1);
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_en      = ($urandom_range(0, 2) == 0);
      wb_addr    = 3'($urandom_range(0, 7));
      wb_data    = 16'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      cyc();
    end
    idle();
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
